// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready arbiter in front of a shared ALU

package InstructionSetPkg;
    localparam int DataWidth      = 16;
    localparam int ImmediateWidth = 8;

    typedef enum logic [3:0] {
        MOVE = 4'd0,
        ADD  = 4'd1,
        ADC  = 4'd2,
        SUB  = 4'd3,
        DIV  = 4'd4,
        MOD  = 4'd5
    } eOperation;

    typedef struct packed {
        logic Sign;
        logic Overflow;
        logic Parity;
        logic Zero;
        logic Carry;
    } sFlags;
endpackage

module alu_arbiter
    import InstructionSetPkg::*;
#(
    parameter bit EnableRoundRobin = 1'b1,
    parameter int CountWidth       = 16
) (
    input  logic                      Clock,
    input  logic                      nReset,
    input  logic [1:0]                ReqValid,
    output logic [1:0]                ReqReady,
    input  eOperation                 ReqOperation [2],
    input  sFlags                     ReqFlags     [2],
    input  logic [ImmediateWidth-1:0] ReqImm       [2],
    input  logic [DataWidth-1:0]      ReqSrc       [2],
    input  logic [DataWidth-1:0]      ReqDest      [2],
    output logic [1:0]                RspValid,
    input  logic [1:0]                RspReady,
    output logic [DataWidth-1:0]      RspDest,
    output sFlags                     RspFlags,
    output logic                      RspError,
    output eOperation                 AluOperation,
    output sFlags                     AluInFlags,
    output logic [ImmediateWidth-1:0] AluImm,
    output logic [DataWidth-1:0]      AluSrc,
    output logic [DataWidth-1:0]      AluDest,
    input  logic [DataWidth-1:0]      AluOutDest,
    input  sFlags                     AluOutFlags,
    output logic [CountWidth-1:0]     GrantCount0,
    output logic [CountWidth-1:0]     GrantCount1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    eOperation                 op_q, op_d;
    sFlags                     flags_q, flags_d;
    logic [ImmediateWidth-1:0] imm_q, imm_d;
    logic [DataWidth-1:0]      src_q, src_d;
    logic [DataWidth-1:0]      dest_q, dest_d;
    logic [DataWidth-1:0]      rsp_dest_q, rsp_dest_d;
    sFlags                     rsp_flags_q, rsp_flags_d;
    logic                      rsp_error_q, rsp_error_d;
    logic [CountWidth-1:0]     cnt0_q, cnt0_d;
    logic [CountWidth-1:0]     cnt1_q, cnt1_d;
    logic                      sel;
    logic                      reject;
    logic [1:0]                req_ready;

    // Pick the requester to serve from the current valids and the last grant
    always_comb begin
        sel = 1'b0;
        if (ReqValid == 2'b11) begin
            sel = EnableRoundRobin ? ~last_grant_q : 1'b0;
        end else begin
            sel = ReqValid[1];
        end
    end

    // Divide or modulo by zero never reaches the ALU
    always_comb begin
        reject = 1'b0;
        if ((ReqOperation[sel] == DIV || ReqOperation[sel] == MOD) && ReqSrc[sel] == '0) begin
            reject = 1'b1;
        end
    end

    // Next-state and register updates for the IDLE/EXEC/RESP sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        flags_d      = flags_q;
        imm_d        = imm_q;
        src_d        = src_q;
        dest_d       = dest_q;
        rsp_dest_d   = rsp_dest_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_error_d  = rsp_error_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        req_ready    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (ReqValid != 2'b00) begin
                    req_ready[sel] = 1'b1;
                    grant_d        = sel;
                    last_grant_d   = sel;
                    op_d           = ReqOperation[sel];
                    flags_d        = ReqFlags[sel];
                    imm_d          = ReqImm[sel];
                    src_d          = ReqSrc[sel];
                    dest_d         = ReqDest[sel];
                    if (sel == 1'b0 && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
                    if (sel == 1'b1 && cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
                    if (reject) begin
                        rsp_dest_d  = '0;
                        rsp_flags_d = ReqFlags[sel];
                        rsp_error_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                rsp_dest_d  = AluOutDest;
                rsp_flags_d = AluOutFlags;
                rsp_error_d = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (RspReady[grant_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared on asynchronous reset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= eOperation'(4'd0);
            flags_q      <= '0;
            imm_q        <= '0;
            src_q        <= '0;
            dest_q       <= '0;
            rsp_dest_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_error_q  <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            flags_q      <= flags_d;
            imm_q        <= imm_d;
            src_q        <= src_d;
            dest_q       <= dest_d;
            rsp_dest_q   <= rsp_dest_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_error_q  <= rsp_error_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // Ready is forced low while reset is asserted so every output reads 0
    assign ReqReady     = nReset ? req_ready : 2'b00;
    assign RspValid     = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign RspDest      = rsp_dest_q;
    assign RspFlags     = rsp_flags_q;
    assign RspError     = rsp_error_q;
    assign AluOperation = op_q;
    assign AluInFlags   = flags_q;
    assign AluImm       = imm_q;
    assign AluSrc       = src_q;
    assign AluDest      = dest_q;
    assign GrantCount0  = cnt0_q;
    assign GrantCount1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed checks of alu_arbiter against a transaction model

module tb_alu_arbiter;
    import InstructionSetPkg::*;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Round-robin instance (default parameters)
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    eOperation   req_op    [2];
    sFlags       req_flags [2];
    logic [7:0]  req_imm   [2];
    logic [15:0] req_src   [2];
    logic [15:0] req_dest  [2];
    logic [15:0] rsp_dest, alu_src, alu_dest, alu_out_dest;
    sFlags       rsp_flags, alu_in_flags, alu_out_flags;
    logic        rsp_error;
    eOperation   alu_op;
    logic [7:0]  alu_imm;
    logic [15:0] cnt0, cnt1;

    // Fixed-priority instance with 2-bit counters
    logic [1:0]  f_valid, f_ready, f_rsp_valid, f_rsp_ready;
    eOperation   f_op    [2];
    sFlags       f_flags [2];
    logic [7:0]  f_imm   [2];
    logic [15:0] f_src   [2];
    logic [15:0] f_dest  [2];
    logic [15:0] f_rsp_dest, f_alu_src, f_alu_dest, f_alu_out_dest;
    sFlags       f_rsp_flags, f_alu_in_flags, f_alu_out_flags;
    logic        f_rsp_error;
    eOperation   f_alu_op;
    logic [7:0]  f_alu_imm;
    logic [1:0]  f_cnt0, f_cnt1;

    // Behavioural ALU: result in [20:5], flags {Sign,Overflow,Parity,Zero,Carry} in [4:0]
    function automatic logic [20:0] alu_f(input logic [3:0] op, input sFlags fl, input logic [7:0] imm,
                                          input logic [15:0] src, input logic [15:0] dest);
        logic [16:0] s;
        logic [15:0] r;
        sFlags       f;
        f = fl;
        s = 17'd0;
        case (op)
            4'd0: r = src;
            4'd1: begin s = dest + src; r = s[15:0]; f.Carry = s[16]; end
            4'd2: begin s = dest + src + fl.Carry; r = s[15:0]; f.Carry = s[16]; end
            4'd3: begin s = {1'b0, dest} - {1'b0, src}; r = s[15:0]; f.Carry = s[16]; end
            4'd4: r = (src == 0) ? 16'hFFFF : dest / src;
            4'd5: r = (src == 0) ? 16'hFFFF : dest % src;
            default: r = dest ^ {8'h00, imm};
        endcase
        f.Zero = (r == 16'd0);
        f.Sign = r[15];
        return {r, f};
    endfunction

    assign {alu_out_dest, alu_out_flags}     = alu_f(alu_op, alu_in_flags, alu_imm, alu_src, alu_dest);
    assign {f_alu_out_dest, f_alu_out_flags} = alu_f(f_alu_op, f_alu_in_flags, f_alu_imm, f_alu_src, f_alu_dest);

    alu_arbiter u_rr (
        .Clock(clk), .nReset(nReset),
        .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqOperation(req_op), .ReqFlags(req_flags), .ReqImm(req_imm), .ReqSrc(req_src), .ReqDest(req_dest),
        .RspValid(rsp_valid), .RspReady(rsp_ready),
        .RspDest(rsp_dest), .RspFlags(rsp_flags), .RspError(rsp_error),
        .AluOperation(alu_op), .AluInFlags(alu_in_flags), .AluImm(alu_imm), .AluSrc(alu_src), .AluDest(alu_dest),
        .AluOutDest(alu_out_dest), .AluOutFlags(alu_out_flags),
        .GrantCount0(cnt0), .GrantCount1(cnt1)
    );

    alu_arbiter #(.EnableRoundRobin(1'b0), .CountWidth(2)) u_fp (
        .Clock(clk), .nReset(nReset),
        .ReqValid(f_valid), .ReqReady(f_ready),
        .ReqOperation(f_op), .ReqFlags(f_flags), .ReqImm(f_imm), .ReqSrc(f_src), .ReqDest(f_dest),
        .RspValid(f_rsp_valid), .RspReady(f_rsp_ready),
        .RspDest(f_rsp_dest), .RspFlags(f_rsp_flags), .RspError(f_rsp_error),
        .AluOperation(f_alu_op), .AluInFlags(f_alu_in_flags), .AluImm(f_alu_imm), .AluSrc(f_alu_src), .AluDest(f_alu_dest),
        .AluOutDest(f_alu_out_dest), .AluOutFlags(f_alu_out_flags),
        .GrantCount0(f_cnt0), .GrantCount1(f_cnt1)
    );

    // Transaction-level model state for the round-robin instance
    int          m_last;
    int          m_cnt [2];
    logic [1:0]  obs_ready;
    logic [15:0] obs_dest;
    logic [1:0]  pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_operands(input int i);
        req_op[i]    = eOperation'(4'($urandom_range(0, 7)));
        req_flags[i] = sFlags'(5'($urandom));
        req_imm[i]   = 8'($urandom);
        req_src[i]   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        req_dest[i]  = 16'($urandom);
    endtask

    // One full transaction on the round-robin instance; called at a negedge with the DUT idle
    task automatic txn(input logic [1:0] v, input int stall);
        int          g;
        bit          err;
        logic [20:0] e;
        logic [1:0]  mask;
        req_valid = v;
        rsp_ready = 2'b00;
        #1;
        g    = (v == 2'b11) ? ((m_last == 1) ? 0 : 1) : (v[1] ? 1 : 0);
        mask = (g == 1) ? 2'b10 : 2'b01;
        obs_ready = req_ready;
        chk("req_ready_accept", req_ready, mask);
        err = (req_op[g] == DIV || req_op[g] == MOD) && req_src[g] == 16'd0;
        e   = err ? {16'd0, req_flags[g]} : alu_f(req_op[g], req_flags[g], req_imm[g], req_src[g], req_dest[g]);
        m_last = g;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        @(negedge clk);
        req_valid = v & ~mask;
        if (!err) begin
            chk("exec_rsp_valid", rsp_valid, 2'b00);
            chk("exec_req_ready", req_ready, 2'b00);
            chk("exec_alu_op", alu_op, req_op[g]);
            chk("exec_alu_src", alu_src, req_src[g]);
            chk("exec_alu_dest", alu_dest, req_dest[g]);
            @(negedge clk);
        end
        chk("rsp_valid", rsp_valid, mask);
        chk("rsp_dest", rsp_dest, e[20:5]);
        chk("rsp_flags", rsp_flags, e[4:0]);
        chk("rsp_error", rsp_error, err);
        obs_dest = rsp_dest;
        for (int s = 0; s < stall; s++) begin
            rsp_ready = ~mask;
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, mask);
            chk("stall_rsp_dest", rsp_dest, e[20:5]);
            chk("stall_rsp_flags", rsp_flags, e[4:0]);
            chk("stall_req_ready", req_ready, 2'b00);
        end
        rsp_ready = mask;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("post_rsp_valid", rsp_valid, 2'b00);
        chk("grant_count0", cnt0, m_cnt[0]);
        chk("grant_count1", cnt1, m_cnt[1]);
        pending = req_valid;
    endtask

    initial begin
        nReset    = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        f_valid   = 2'b00;
        f_rsp_ready = 2'b00;
        pending   = 2'b00;
        m_last    = 1;
        m_cnt[0]  = 0;
        m_cnt[1]  = 0;
        for (int i = 0; i < 2; i++) begin
            rand_operands(i);
            f_op[i] = MOVE; f_flags[i] = '0; f_imm[i] = '0; f_src[i] = '0; f_dest[i] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_alu_op", alu_op, 4'd0);
        chk("reset_rsp_dest", rsp_dest, 16'd0);
        chk("reset_cnt0", cnt0, 16'd0);
        nReset = 1'b1;
        @(negedge clk);

        // Both requesters held valid with MOVE ops: grants alternate starting with 0
        for (int i = 0; i < 4; i++) begin
            req_op[0] = MOVE; req_op[1] = MOVE;
            req_src[0] = 16'(100 + i); req_src[1] = 16'(200 + i);
            txn(2'b11, 0);
            chk("t2_order", obs_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        chk("t2_cnt0", cnt0, 16'd2);
        chk("t2_cnt1", cnt1, 16'd2);

        // ADC 4 + 3 + carry
        req_op[0] = ADC; req_src[0] = 16'd3; req_dest[0] = 16'd4; req_flags[0] = sFlags'(5'b00001);
        txn(2'b01, 0);
        chk("t1_dest", obs_dest, 16'd8);
        chk("t1_carry_zero", {rsp_flags.Zero, rsp_flags.Carry}, 2'b00);

        // Requester 1 DIV by zero is rejected with flags passed back
        req_op[1] = DIV; req_src[1] = 16'd0; req_dest[1] = 16'd10; req_flags[1] = sFlags'(5'b10101);
        txn(2'b10, 0);
        chk("t3_dest", obs_dest, 16'd0);

        // Long stall in RESP while requester 1 waits, then it is served next
        req_op[0] = SUB; req_src[0] = 16'd5; req_dest[0] = 16'd9;
        req_op[1] = ADD; req_src[1] = 16'd1; req_dest[1] = 16'd2;
        txn(2'b11, 5);
        chk("t4_pending", pending, 2'b10);
        txn(pending, 0);
        chk("t4_granted_1", obs_ready, 2'b10);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [1:0] v;
            v = pending | 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) if (!pending[i]) rand_operands(i);
            txn(v, $urandom_range(0, 3));
        end
        if (pending != 2'b00) txn(pending, 0);

        // Asynchronous reset during EXEC discards the transaction
        req_op[0] = ADD; req_src[0] = 16'd7; req_dest[0] = 16'd7;
        req_valid = 2'b01;
        #1 chk("t5_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk("t5_in_exec_alu_src", alu_src, 16'd7);
        #2 nReset = 1'b0;
        #1;
        chk("t5_rsp_valid", rsp_valid, 2'b00);
        chk("t5_alu_src", alu_src, 16'd0);
        chk("t5_alu_op", alu_op, 4'd0);
        chk("t5_rsp_dest", rsp_dest, 16'd0);
        chk("t5_cnt0", cnt0, 16'd0);
        chk("t5_cnt1", cnt1, 16'd0);
        @(negedge clk);
        nReset   = 1'b1;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_response", rsp_valid, 2'b00);
        end
        req_op[0] = MOVE; req_op[1] = MOVE;
        txn(2'b11, 0);
        chk("t5_first_grant", obs_ready, 2'b01);

        // Fixed priority instance: requester 0 always wins, counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            f_src[0] = 16'($urandom);
            f_valid = 2'b11;
            #1 chk("fp_ready", f_ready, 2'b01);
            @(negedge clk);
            f_valid = 2'b00;
            @(negedge clk);
            chk("fp_rsp_valid", f_rsp_valid, 2'b01);
            chk("fp_rsp_dest", f_rsp_dest, f_src[0]);
            f_rsp_ready = 2'b01;
            @(negedge clk);
            f_rsp_ready = 2'b00;
            chk("fp_cnt0", f_cnt0, (i + 1 > 3) ? 3 : i + 1);
        end
        chk("fp_cnt1", f_cnt1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
